// File: rtl/disp_sched_pkg.sv
// Shared types and helpers for the display page scheduler.
package disp_sched_pkg;

  localparam int NSRC = 4;
  localparam int CNT_W_DEF = 27;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHOW   = 2'd1,
    ST_PINNED = 2'd2,
    ST_ALERT  = 2'd3
  } state_t;

  function automatic logic [63:0] src_slice(input logic [255:0] bus, input logic [1:0] idx);
    return bus[{idx, 6'd0} +: 64];
  endfunction

endpackage

// File: rtl/disp_rr_pick.sv
// Round-robin picker: first valid index strictly after start, wrapping, start itself last.
module disp_rr_pick (
  input  logic [3:0] valid,
  input  logic [1:0] start,
  output logic [1:0] next,
  output logic       any
);

  logic [1:0] idx;

  // Scan farthest-first so the nearest valid index after start wins.
  always_comb begin
    next = start;
    idx  = start;
    for (int k = 4; k >= 1; k--) begin
      idx = start + 2'(k);
      if (valid[idx]) next = idx;
    end
    any = |valid;
  end

endmodule

// File: rtl/disp_page_sched.sv
// Time-shares the hex display among four sources: round-robin dwell, manual advance, pin and alert preemption.
module disp_page_sched
  import disp_sched_pkg::*;
#(
  parameter int DWELL      = 27000000,
  parameter int ALERT_HOLD = 81000000,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic         clock_27mhz,
  input  logic         reset,
  input  logic [3:0]   src_valid,
  input  logic [255:0] src_data,
  input  logic         next_pulse,
  input  logic         pin_en,
  input  logic [1:0]   pin_sel,
  input  logic [3:0]   alert,
  output logic [63:0]  disp_data,
  output logic [1:0]   cur_page,
  output logic         page_valid,
  output logic         in_alert
);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(ALERT_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  state_t             state, state_n;
  logic [1:0]         page_n;
  logic [CNT_W-1:0]   cnt, cnt_n, cnt_inc;
  logic [NSRC-1:0]    alert_q, alert_edge;
  logic [1:0]         alert_idx;
  logic               alert_hit;
  logic [1:0]         rr_start, rr_next;
  logic               rr_any;
  logic               cur_ok, show_ok;

  // From IDLE a start of 3 makes the picker return the lowest valid index.
  assign rr_start = (state == ST_IDLE) ? 2'd3 : cur_page;

  disp_rr_pick u_pick (
    .valid (src_valid),
    .start (rr_start),
    .next  (rr_next),
    .any   (rr_any)
  );

  assign cur_ok  = src_valid[cur_page];
  assign show_ok = (state != ST_IDLE) && cur_ok;
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

  always_comb begin
    alert_edge = alert & ~alert_q & src_valid;
    alert_hit  = |alert_edge;
    alert_idx  = 2'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (alert_edge[i]) alert_idx = 2'(i);
    end
  end

  always_comb begin
    state_n = state;
    page_n  = cur_page;
    cnt_n   = '0;
    if (pin_en) begin
      state_n = ST_PINNED;
      page_n  = pin_sel;
    end else if (state == ST_PINNED) begin
      state_n = rr_any ? ST_SHOW : ST_IDLE;
      if (!cur_ok) page_n = rr_next;
    end else if (alert_hit) begin
      state_n = ST_ALERT;
      page_n  = alert_idx;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rr_any) begin
            state_n = ST_SHOW;
            page_n  = rr_next;
          end
        end
        ST_SHOW: begin
          if (!rr_any) begin
            state_n = ST_IDLE;
          end else if (!cur_ok || next_pulse || cnt == DWELL_LAST) begin
            page_n = rr_next;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        ST_ALERT: begin
          if (!cur_ok) begin
            state_n = rr_any ? ST_SHOW : ST_IDLE;
            page_n  = rr_next;
          end else if (cnt >= HOLD_LAST && !alert[cur_page]) begin
            state_n = ST_SHOW;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // Registered outputs: display word follows the page chosen one cycle earlier.
  always_ff @(posedge clock_27mhz) begin
    if (reset) begin
      state      <= ST_IDLE;
      cur_page   <= 2'd0;
      cnt        <= '0;
      alert_q    <= '0;
      disp_data  <= '0;
      page_valid <= 1'b0;
      in_alert   <= 1'b0;
    end else begin
      state      <= state_n;
      cur_page   <= page_n;
      cnt        <= cnt_n;
      alert_q    <= alert;
      disp_data  <= show_ok ? src_slice(src_data, cur_page) : 64'd0;
      page_valid <= show_ok;
      in_alert   <= (state_n == ST_ALERT);
    end
  end

endmodule
